// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812B frame sequencer.
// Holds the FSM state enum, GRB word width, default timings and colours.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_e;

    localparam int GRB_W = 24;

    // 300 us latch gap and 60 Hz frame period at 100 MHz
    localparam int DEF_RESET_CYCLES = 30000;
    localparam int DEF_FRAME_CYCLES = 1666667;

    // GRB ordering: G[23:16] R[15:8] B[7:0]
    localparam logic [GRB_W-1:0] GRB_OFF   = 24'h000000;
    localparam logic [GRB_W-1:0] GRB_RED   = 24'h00FF00;
    localparam logic [GRB_W-1:0] GRB_GREEN = 24'hFF0000;
    localparam logic [GRB_W-1:0] GRB_BLUE  = 24'h0000FF;

    function automatic int clamp_leds(input int req, input int max_leds);
        return (req > max_leds) ? max_leds : req;
    endfunction

endpackage

// File: rtl/ws_delay_counter.sv
// Loadable down-counter that emits a one-cycle done pulse.
// Ports: clk, reset, load_i, load_val_i -> done_o (registered pulse).
module ws_delay_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic         done_q;

    // Loading V raises done_o V cycles after the load edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (load_i) begin
            cnt_q  <= load_val_i;
            done_q <= 1'b0;
        end else begin
            done_q <= (cnt_q == W'(1));
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - W'(1);
            end
        end
    end

    assign done_o = done_q;

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Frame controller: colour table, frame snapshot, GRB streaming, latch gap.
// Ports: table write (wr_*), frame control (go/auto/num_leds), px_* stream.
module ws2812_frame_sequencer
    import ws2812_pkg::*;
#(
    parameter int MAX_LEDS     = 8,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       num_leds,
    input  logic             go,
    input  logic             auto,
    input  logic             wr_en,
    input  logic [2:0]       wr_addr,
    input  logic [GRB_W-1:0] wr_data,
    output logic [GRB_W-1:0] px_data,
    output logic             px_valid,
    input  logic             px_ready,
    output logic             ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int IDX_W = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1;
    localparam int CNT_W = $clog2(MAX_LEDS + 1);
    localparam int PER_W = $clog2(FRAME_CYCLES);
    localparam int DLY_W = $clog2(RESET_CYCLES);

    state_e           state_q;
    logic [GRB_W-1:0] tbl_q  [MAX_LEDS];
    logic [GRB_W-1:0] snap_q [MAX_LEDS];
    logic [GRB_W-1:0] snap_d [MAX_LEDS];
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] n_d;
    logic [PER_W-1:0] per_q;
    logic [GRB_W-1:0] px_data_q;
    logic             px_valid_q;
    logic             ready_q;
    logic             busy_q;
    logic             frame_done_q;

    logic wr_ok;
    logic per_exp;
    logic xfer;
    logic last;
    logic start;
    logic dly_load;
    logic dly_done;

    assign wr_ok    = wr_en && (int'(wr_addr) < MAX_LEDS);
    assign n_d      = CNT_W'(clamp_leds(int'(num_leds), MAX_LEDS));
    assign per_exp  = (per_q == PER_W'(FRAME_CYCLES - 1));
    assign xfer     = px_valid_q && px_ready;
    assign last     = (CNT_W'(idx_q) == n_q - CNT_W'(1));
    assign start    = (state_q == IDLE) && (n_d != '0)
                   && (go || (auto && per_exp));
    assign dly_load = (state_q == SEND) && xfer && last;

    // Snapshot source: table with a same-cycle write forwarded in.
    always_comb begin
        for (int i = 0; i < MAX_LEDS; i++) begin
            snap_d[i] = tbl_q[i];
        end
        if (wr_ok) begin
            snap_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tbl_q <= '{default: '0};
        end else if (wr_ok) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    ws_delay_counter #(
        .W (DLY_W)
    ) u_latch_dly (
        .clk        (clk),
        .reset      (reset),
        .load_i     (dly_load),
        .load_val_i (DLY_W'(RESET_CYCLES - 1)),
        .done_o     (dly_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            snap_q       <= '{default: '0};
            idx_q        <= '0;
            n_q          <= '0;
            per_q        <= '0;
            px_data_q    <= GRB_OFF;
            px_valid_q   <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // Period counter saturates; the start branch restarts it.
            if (!per_exp) begin
                per_q <= per_q + PER_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_q     <= snap_d;
                        n_q        <= n_d;
                        idx_q      <= '0;
                        per_q      <= '0;
                        px_data_q  <= snap_d[0];
                        px_valid_q <= 1'b1;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (last) begin
                            px_valid_q <= 1'b0;
                            px_data_q  <= GRB_OFF;
                            state_q    <= LATCH;
                        end else begin
                            idx_q     <= idx_q + IDX_W'(1);
                            px_data_q <= snap_q[idx_q + IDX_W'(1)];
                        end
                    end
                end
                LATCH: begin
                    if (dly_done) begin
                        state_q      <= IDLE;
                        ready_q      <= 1'b1;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign px_data    = px_data_q;
    assign px_valid   = px_valid_q;
    assign ready      = ready_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/ws2812_frame_sequencer.md
Name: ws2812_frame_sequencer

Overview:
- Frame-level controller for the WS2812B strip datapath: holds a per-LED GRB colour table, snapshots it at frame start, and streams one 24-bit GRB word per LED to the pixel sender over a valid/ready handshake.
- Enforces the >280 us latch/reset gap after each frame.
- Frames start on a one-shot `go` request or automatically at a fixed frame period.
- Sits between host/pattern logic and the bit-level GRB/NZR sender chain, replacing the single-colour Go/Ready2Go sequencing.

Parameters:
- MAX_LEDS, 8, colour table depth; num_leds is clamped to this value.
- RESET_CYCLES, 30000, latch gap in clk cycles (300 us at 100 MHz); must be >= 2.
- FRAME_CYCLES, 1666667, auto-mode frame period in clk cycles (60 Hz at 100 MHz); must be >= 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- num_leds  in  4  LEDs per frame, 0..15; values > MAX_LEDS are treated as MAX_LEDS; 0 means no frame is started.
- go  in  1  level-sampled frame request, honoured only in IDLE.
- auto  in  1  when 1, frames restart every FRAME_CYCLES.
- wr_en  in  1  colour table write strobe.
- wr_addr  in  3  colour table index.
- wr_data  in  24  GRB colour, G[23:16] R[15:8] B[7:0].
- px_data  out  24  GRB word for the current LED.
- px_valid  out  1  px_data is valid.
- px_ready  in  1  sender accepts px_data this cycle.
- ready  out  1  high in IDLE (Ready2Go equivalent).
- busy  out  1  high in SEND or LATCH.
- frame_done  out  1  one-cycle pulse when the latch gap completes.

Behaviour:
- All outputs are registered.
- Reset:
  - Enters IDLE and clears the table, snapshot, index, timers and period counter to 0.
  - After the reset edge: px_valid=0, px_data=0, busy=0, frame_done=0, ready=1.
  - Reset mid-frame aborts immediately with no partial-frame completion and no frame_done.
- Table writes:
  - Accepted in every state; wr_addr >= MAX_LEDS is ignored.
  - Writes never disturb the frame in progress, because the frame uses the snapshot.
- Start condition, in IDLE only, with n = min(num_leds, MAX_LEDS) != 0: go=1, or auto=1 with the period counter expired.
- In the start cycle:
  - Snapshot <= table; a write in the same cycle is forwarded into the snapshot.
  - n is latched, index=0, period counter reset to 0, state moves to SEND.
  - ready falls and busy rises on the same edge.
- SEND:
  - px_valid=1 and px_data=snap[index] from the cycle after the start edge; this is the latency.
  - A transfer occurs on a cycle with px_valid&&px_ready; the index then increments.
  - px_data is held stable while px_ready=0.
  - The transfer of index n-1 moves the state to LATCH; px_valid=0 on the next cycle.
- LATCH:
  - px_valid=0 for exactly RESET_CYCLES cycles, counted by the delay sub-module.
  - Then frame_done=1 for 1 cycle, concurrent with the return to IDLE (ready=1).
- Period counter:
  - Counts up from frame start and saturates at FRAME_CYCLES-1 ("expired").
  - If expired before LATCH ends and auto=1, the next frame starts on the first IDLE cycle: back-to-back operation with exactly one IDLE cycle between frames.
- go or auto during SEND/LATCH is ignored (no queueing).
- auto deasserted mid-frame: the current frame completes and no restart follows.
- num_leds changes mid-frame have no effect until the next start.
- go held high continuously: frames repeat with one IDLE cycle between them.

Decomposition:
- Shared package ws2812_pkg:
  - State enum {IDLE, SEND, LATCH}.
  - GRB_W=24.
  - Default RESET_CYCLES/FRAME_CYCLES constants.
  - GRB colour constants (OFF, RED=24'h00FF00, GREEN=24'hFF0000, BLUE=24'h0000FF).
- One sub-module ws_delay_counter:
  - Loadable down-counter with a done pulse, parameterised width.
  - Used for the latch gap.
  - The period counter stays inline.

Test Plan (RESET_CYCLES=10, FRAME_CYCLES=100):
- Reset, write table[0..2]=FF0000,00FF00,0000FF, num_leds=3, pulse go with px_ready=1 -> px_data sequence FF0000,00FF00,0000FF on 3 consecutive cycles starting 1 cycle after go; then px_valid=0 for 10 cycles; frame_done pulses once; ready=1.
- px_ready toggles 1,0,0,1 during SEND -> px_data is held while px_ready=0; no word is skipped or duplicated; 3 transfers total.
- Write table[1]=123456 during SEND -> the current frame sends the old value; the next frame sends 123456.
- auto=1, num_leds=2 -> frame starts at cycles 0,100,200 (±0); with FRAME_CYCLES=5, frames run back-to-back with 1 IDLE cycle between them.
- num_leds=0 with go=1 -> ready stays 1 and px_valid stays 0; num_leds=12 -> exactly 8 words sent.
- Assert reset during LATCH and during SEND -> next cycle px_valid=0, ready=1, no frame_done; table reads back 0 on the next frame.
